// File: rtl/if_fetch_align.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : if_fetch_align                                                   |
// | Purpose  : RV32IC fetch stage; realigns 16/32-bit instructions from imem.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+

module if_fetch_align #(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  id_ready,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_is_rvc
);

  localparam logic [2:0] C_BUF_DEPTH = 3'd4;

  logic [ADDR_WIDTH-1:0] r_wp;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic                  r_drop_low;
  logic [15:0]           r_buf [4];
  logic [2:0]            r_cnt;
  logic [31:0]           r_pc;

  logic [15:0] w_hw0;
  logic        w_is_rvc;
  logic [1:0]  w_pop;
  logic [1:0]  w_shift;
  logic        w_fire;
  logic [2:0]  w_cnt_rem;
  logic [2:0]  w_in_hw;
  logic        w_accept;
  logic [2:0]  w_cnt_nxt;
  logic [15:0] w_buf_nxt [4];

  assign imem_addr = redirect_valid ? redirect_pc[ADDR_WIDTH+1:2] : r_wp;

  assign w_hw0        = r_buf[0];
  assign w_is_rvc     = (w_hw0[1:0] != 2'b11);
  assign w_pop        = w_is_rvc ? 2'd1 : 2'd2;
  assign instr_valid  = w_is_rvc ? (r_cnt != 3'd0) : (r_cnt >= 3'd2);
  assign instr        = w_is_rvc ? {16'h0, w_hw0} : {r_buf[1], w_hw0};
  assign instr_pc     = r_pc;
  assign instr_is_rvc = w_is_rvc;

  assign w_fire    = instr_valid & id_ready & ~redirect_valid;
  assign w_shift   = w_fire ? w_pop : 2'd0;
  assign w_cnt_rem = r_cnt - {1'b0, w_shift};
  assign w_in_hw   = r_drop_low ? 3'd1 : 3'd2;
  assign w_accept  = r_rsp_valid && ((w_cnt_rem + w_in_hw) <= C_BUF_DEPTH);
  assign w_cnt_nxt = w_cnt_rem + (w_accept ? w_in_hw : 3'd0);

  // Pop and append in one step; slots past w_cnt_rem are don't-care, so the
  // shift index may simply wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_buf_nxt[i] = r_buf[2'(i) + w_shift];
      if (w_accept) begin
        if (r_drop_low) begin
          if (3'(i) == w_cnt_rem) w_buf_nxt[i] = imem_dout[31:16];
        end else begin
          if (3'(i) == w_cnt_rem)        w_buf_nxt[i] = imem_dout[15:0];
          if (3'(i) == w_cnt_rem + 3'd1) w_buf_nxt[i] = imem_dout[31:16];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp        <= RESET_PC[ADDR_WIDTH+1:2];
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_drop_low  <= RESET_PC[1];
      r_cnt       <= 3'd0;
      r_pc        <= RESET_PC;
      for (int i = 0; i < 4; i++) r_buf[i] <= 16'h0;
    end else begin
      r_rsp_valid <= 1'b1;
      r_rsp_addr  <= imem_addr;
      r_wp        <= imem_addr + 1'b1;
      if (redirect_valid) begin
        r_cnt      <= 3'd0;
        r_pc       <= redirect_pc & ~32'h1;
        r_drop_low <= redirect_pc[1];
      end else begin
        r_cnt <= w_cnt_nxt;
        r_buf <= w_buf_nxt;
        if (w_fire)   r_pc       <= r_pc + {29'h0, w_pop, 1'b0};
        if (w_accept) r_drop_low <= 1'b0;
        // Full buffer: drop the word, squash the in-flight request, replay.
        if (r_rsp_valid && !w_accept) begin
          r_wp        <= r_rsp_addr;
          r_rsp_valid <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_align.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_if_fetch_align                                                |
// | Purpose  : Directed self-checking bench for if_fetch_align.                 |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+

module tb_if_fetch_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] imem_addr;
  logic [31:0] imem_dout = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_is_rvc;

  logic [31:0] mem [2048];
  int checks = 0;
  int failures = 0;

  if_fetch_align #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_is_rvc(instr_is_rvc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_dout <= mem[imem_addr];

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (instr_valid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (imem_addr !== 11'h0) begin failures++; $display("FAIL reset_addr got=%h exp=000", imem_addr); end
  endtask

  task automatic test_reset_release();
    logic [31:0] ei [3] = '{32'h00100093, 32'h00200113, 32'h00300193};
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL release_c1_valid got=%b exp=0", instr_valid); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== ei[i] || instr_pc !== 32'(4*i) || instr_is_rvc !== 1'b0) begin
        failures++;
        $display("FAIL release_instr%0d got v=%b i=%h pc=%h rvc=%b exp v=1 i=%h pc=%h rvc=0",
                 i, instr_valid, instr, instr_pc, instr_is_rvc, ei[i], 32'(4*i));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rvc_straddle();
    logic [31:0] ei [3] = '{32'h00004505, 32'h00100093, 32'h0000ABCD};
    logic [31:0] ep [3] = '{32'h40, 32'h42, 32'h46};
    logic        er [3] = '{1'b1, 1'b0, 1'b1};
    bit ok;
    do_redirect(32'h40);
    wait_valid(ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!ok || instr_valid !== 1'b1 || instr !== ei[i] || instr_pc !== ep[i] || instr_is_rvc !== er[i]) begin
        failures++;
        $display("FAIL straddle%0d got v=%b i=%h pc=%h rvc=%b exp v=1 i=%h pc=%h rvc=%b",
                 i, instr_valid, instr, instr_pc, instr_is_rvc, ei[i], ep[i], er[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall_replay();
    logic [31:0] ei [14] = '{32'h4505, 32'h00100093, 32'h4111, 32'h8082, 32'h00200113, 32'h4501,
                             32'h00300193, 32'h4605, 32'h4705, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
    logic [31:0] ep [14] = '{32'h80, 32'h82, 32'h86, 32'h88, 32'h8A, 32'h8E, 32'h90,
                             32'h94, 32'h96, 32'h98, 32'h9A, 32'h9C, 32'h9E, 32'hA0};
    int  idx = 0;
    bit  stalled = 1'b0;
    id_ready = 1'b1;
    do_redirect(32'h80);
    for (int guard = 0; guard < 100 && idx < 14; guard++) begin
      if (instr_valid) begin
        if (idx == 3 && !stalled) begin
          stalled = 1'b1;
          id_ready = 1'b0;
          for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== ei[3] || instr_pc !== ep[3]) begin
              failures++;
              $display("FAIL stall_hold%0d got v=%b i=%h pc=%h exp v=1 i=%h pc=%h",
                       s, instr_valid, instr, instr_pc, ei[3], ep[3]);
            end
          end
          id_ready = 1'b1;
        end
        checks++;
        if (instr !== ei[idx] || instr_pc !== ep[idx]) begin
          failures++;
          $display("FAIL stream%0d got i=%h pc=%h exp i=%h pc=%h", idx, instr, instr_pc, ei[idx], ep[idx]);
        end
        idx++;
      end
      @(negedge clk);
    end
    checks++; if (idx != 14) begin failures++; $display("FAIL stream_count got=%0d exp=14", idx); end
  endtask

  task automatic test_redirect_unaligned();
    bit ok;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h106;
    #1;
    checks++; if (imem_addr !== 11'h41) begin failures++; $display("FAIL redir_addr got=%h exp=041", imem_addr); end
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok || instr !== 32'h00100093 || instr_pc !== 32'h106 || instr_is_rvc !== 1'b0) begin
      failures++;
      $display("FAIL redir_first got v=%b i=%h pc=%h exp v=1 i=00100093 pc=00000106", instr_valid, instr, instr_pc);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h1 || instr_pc !== 32'h10A) begin
      failures++;
      $display("FAIL redir_second got v=%b i=%h pc=%h exp v=1 i=00000001 pc=0000010a", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_redirect_while_firing();
    bit ok;
    do_redirect(32'h0);
    wait_valid(ok);
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", instr_valid); end
    wait_valid(ok);
    checks++;
    if (!ok || instr !== 32'h4505 || instr_pc !== 32'h80) begin
      failures++;
      $display("FAIL flush_first got v=%b i=%h pc=%h exp v=1 i=00004505 pc=00000080", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_async_reset();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", instr_valid); end
    checks++; if (imem_addr !== 11'h0) begin failures++; $display("FAIL async_rst_addr got=%h exp=000", imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00100093 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL async_restart got v=%b i=%h pc=%h exp v=1 i=00100093 pc=00000000", instr_valid, instr, instr_pc);
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 32'h00010001;
    mem[0] = 32'h00100093; mem[1] = 32'h00200113; mem[2] = 32'h00300193;
    mem[16'h10] = 32'h00934505; mem[16'h11] = 32'hABCD0010;
    mem[16'h20] = 32'h00934505; mem[16'h21] = 32'h41110010; mem[16'h22] = 32'h01138082;
    mem[16'h23] = 32'h45010020; mem[16'h24] = 32'h00300193; mem[16'h25] = 32'h47054605;
    mem[16'h41] = 32'h0093FFFF; mem[16'h42] = 32'h00010010;

    @(negedge clk);
    test_reset();
    test_reset_release();
    test_rvc_straddle();
    test_stall_replay();
    test_redirect_unaligned();
    test_redirect_while_firing();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
